// File: rtl/mdu_pkg.sv
// Shared op encodings and controller types for the multiply/divide unit.
// Optional accumulate ops are enabled by defining MDU_MADD_EN.
package mdu_pkg;

  localparam int MDU_OP_W = 4;
  localparam int CNT_W    = 6;

  localparam logic [MDU_OP_W-1:0] OP_NOP   = 4'd0;
  localparam logic [MDU_OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [MDU_OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [MDU_OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [MDU_OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [MDU_OP_W-1:0] OP_MTHI  = 4'd5;
  localparam logic [MDU_OP_W-1:0] OP_MTLO  = 4'd6;
  localparam logic [MDU_OP_W-1:0] OP_MADD  = 4'd7;
  localparam logic [MDU_OP_W-1:0] OP_MADDU = 4'd8;
  localparam logic [MDU_OP_W-1:0] OP_MSUB  = 4'd9;
  localparam logic [MDU_OP_W-1:0] OP_MSUBU = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for MULT_CYCLES.
  function automatic logic is_mul_op(input logic [MDU_OP_W-1:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) ||
             (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational result path: computes the next {HI,LO} for multiply/divide ops.
// Accumulate ops (MADD/MSUB family) exist only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MDU_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  input  logic [WIDTH-1:0]    hi_i,
  input  logic [WIDTH-1:0]    lo_i,
  output logic [WIDTH-1:0]    hi_d_o,
  output logic [WIDTH-1:0]    lo_d_o
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] a_sx, b_sx, prod_s;
  logic [2*WIDTH-1:0]        prod_u;
  logic                      b_zero, div_ovf;
  logic [WIDTH-1:0]          b_sdiv, b_udiv;
  logic signed [WIDTH-1:0]   q_s, r_s;
  logic [WIDTH-1:0]          q_u, r_u;

  assign a_sx   = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign b_sx   = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  // Divisors are steered away from 0 and from the overflow pair so the
  // dividers never see an undefined case; those results are muxed out below.
  assign b_zero  = (b_i == '0);
  assign div_ovf = (a_i == MOST_NEG) && (b_i == '1);
  assign b_sdiv  = (b_zero || div_ovf) ? WIDTH'(1) : b_i;
  assign b_udiv  = b_zero ? WIDTH'(1) : b_i;
  assign q_s     = $signed(a_i) / $signed(b_sdiv);
  assign r_s     = $signed(a_i) % $signed(b_sdiv);
  assign q_u     = a_i / b_udiv;
  assign r_u     = a_i % b_udiv;

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] acc;
  assign acc = {hi_i, lo_i};
`endif

  always_comb begin
    hi_d_o = hi_i;
    lo_d_o = lo_i;
    case (op_i)
      OP_MULT:  {hi_d_o, lo_d_o} = prod_s;
      OP_MULTU: {hi_d_o, lo_d_o} = prod_u;
      OP_DIV: begin
        if (div_ovf) begin
          hi_d_o = '0;
          lo_d_o = a_i;
        end else if (!b_zero) begin
          hi_d_o = r_s;
          lo_d_o = q_s;
        end
      end
      OP_DIVU: begin
        if (!b_zero) begin
          hi_d_o = r_u;
          lo_d_o = q_u;
        end
      end
`ifdef MDU_MADD_EN
      OP_MADD:  {hi_d_o, lo_d_o} = acc + prod_s;
      OP_MADDU: {hi_d_o, lo_d_o} = acc + prod_u;
      OP_MSUB:  {hi_d_o, lo_d_o} = acc - prod_s;
      OP_MSUBU: {hi_d_o, lo_d_o} = acc - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: IDLE/RUN controller, latency counter, staging and HI/LO.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                busy,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo,
  output logic                dbg_state_o
);

  localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] stage_hi_q, stage_lo_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] hi_d, lo_d;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op_i   (op),
    .a_i    (a),
    .b_i    (b),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .hi_d_o (hi_d),
    .lo_d_o (lo_d)
  );

  // Handshake: start is a one-cycle request sampled with op/a/b; it is
  // only honoured in IDLE, and requests arriving while busy=1 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      stage_hi_q <= '0;
      stage_lo_q <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (is_mul_op(op) || is_div_op(op)) begin
              stage_hi_q <= hi_d;
              stage_lo_q <= lo_d;
              cnt_q      <= is_div_op(op) ? DIV_LAT : MULT_LAT;
              state_q    <= ST_RUN;
            end else if (op == OP_MTHI) begin
              hi_q <= a;
            end else if (op == OP_MTLO) begin
              lo_q <= a;
            end
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            hi_q    <= stage_hi_q;
            lo_q    <= stage_lo_q;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule
